// File: rtl/mem_access_ctrl_if.sv
// Request/response bus for mem_access_ctrl. The master issues accesses and
// the slave (the controller) answers with a single-cycle completion pulse.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_dbl;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [2*DATA_W-1:0]   rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_dbl, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_dbl, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences 1- or 2-word reads/writes onto a single-port memory that reads at
// posedge and writes at negedge; every memory-side output is a posedge register.
module mem_access_ctrl #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 10,
    parameter int MEM_DEPTH = 21504
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_row,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, RD1, RD2, RD3, WR1, WR2} state_t;

    state_t              state, state_d;
    logic                dbl_q, dbl_d;
    logic [ADDR_W-1:0]   addr_inc, addr_inc_q, addr_inc_d;
    logic [DATA_W-1:0]   wlo_q, wlo_d;
    logic [DATA_W-1:0]   rd_hi_q, rd_hi_d;
    logic                wr_pend, wr_pend_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                mem_row_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [2*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                range_err;

    assign addr_inc  = bus.req_addr + ADDR_W'(1);
    assign range_err = ({1'b0, bus.req_addr} >= DEPTH) ||
                       (bus.req_dbl && ({1'b0, addr_inc} >= DEPTH));

    // A finished write holds off new requests for one IDLE cycle while its
    // completion pulse goes out, so writes and reads share the same latency.
    assign bus.req_ready = (state == IDLE) && !wr_pend;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d     = state;
        dbl_d       = dbl_q;
        addr_inc_d  = addr_inc_q;
        wlo_d       = wlo_q;
        rd_hi_d     = rd_hi_q;
        wr_pend_d   = 1'b0;
        mem_addr_d  = mem_addr;
        mem_row_d   = 1'b0;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state)
            IDLE: begin
                if (wr_pend) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.req_valid) begin
                    if (range_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        dbl_d      = bus.req_dbl;
                        addr_inc_d = addr_inc;
                        wlo_d      = bus.req_wdata[DATA_W-1:0];
                        mem_addr_d = bus.req_addr;
                        if (bus.req_write) begin
                            state_d     = WR1;
                            mem_row_d   = 1'b1;
                            mem_wdata_d = bus.req_dbl ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                                      : bus.req_wdata[DATA_W-1:0];
                        end else begin
                            state_d = RD1;
                        end
                    end
                end
            end
            RD1: begin
                if (dbl_q) begin
                    mem_addr_d = addr_inc_q;
                    state_d    = RD2;
                end else begin
                    state_d = RD3;
                end
            end
            RD2: begin
                rd_hi_d = mem_rdata;
                state_d = RD3;
            end
            RD3: begin
                rsp_rdata_d = dbl_q ? {rd_hi_q, mem_rdata} : {{DATA_W{1'b0}}, mem_rdata};
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            WR1: begin
                if (dbl_q) begin
                    mem_addr_d  = addr_inc_q;
                    mem_row_d   = 1'b1;
                    mem_wdata_d = wlo_q;
                    state_d     = WR2;
                end else begin
                    wr_pend_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WR2: begin
                wr_pend_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Asynchronous reset drops mem_row at once, cancelling any pending negedge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbl_q       <= 1'b0;
            addr_inc_q  <= '0;
            wlo_q       <= '0;
            rd_hi_q     <= '0;
            wr_pend     <= 1'b0;
            mem_addr    <= '0;
            mem_row     <= 1'b0;
            mem_wdata   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            dbl_q       <= dbl_d;
            addr_inc_q  <= addr_inc_d;
            wlo_q       <= wlo_d;
            rd_hi_q     <= rd_hi_d;
            wr_pend     <= wr_pend_d;
            mem_addr    <= mem_addr_d;
            mem_row     <= mem_row_d;
            mem_wdata   <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and small random checks of mem_access_ctrl against a behavioural
// memory (posedge read latch, negedge write) and a reference word array.
module tb_mem_access_ctrl;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 10;
    localparam int MEM_DEPTH = 21504;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_row;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [0:MEM_DEPTH-1];
    int                wr_count;
    int                n_cmp;
    int                n_bad;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_row   (mem_row),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_row) begin
            if (int'(mem_addr) < MEM_DEPTH) mem_rdata <= ram[mem_addr];
            else                            mem_rdata <= '0;
        end
    end

    always @(negedge clk) begin
        if (mem_row) begin
            if (int'(mem_addr) < MEM_DEPTH) ram[mem_addr] = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request, then watch until the completion pulse (bounded).
    task automatic applyStimulus(input logic wr, input logic dbl, input logic [ADDR_W-1:0] addr,
                                 input logic [2*DATA_W-1:0] wdata, output int wait_cyc,
                                 output int lat, output int row_cyc,
                                 output logic [2*DATA_W-1:0] rdata, output logic err);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_dbl   = dbl;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        wait_cyc = 0;
        while (!bus.req_ready && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        lat = -1;
        row_cyc = 0;
        rdata = '0;
        err = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            if (i == 0) begin
                bus.req_valid = 1'b0;
                bus.req_write = ~wr;
                bus.req_dbl   = ~dbl;
                bus.req_addr  = 20'h0ABCD;
                bus.req_wdata = 20'hFFFFF;
            end
            if (bus.rsp_valid) begin
                lat   = i;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
            if (mem_row) row_cyc++;
        end
    endtask

    int                  wc, lat, rc, exp_wr, vcount;
    logic [2*DATA_W-1:0] rd;
    logic                er;
    logic [DATA_W-1:0]   ref_mem [0:31];
    logic [2*DATA_W-1:0] exp_rd;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        wr_count = 0;
        mem_rdata = '0;
        for (int i = 0; i < MEM_DEPTH; i++) ram[i] = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_dbl   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready",     32'(bus.req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        checkOutput("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        checkOutput("rst_mem_addr",  32'(mem_addr),      32'd0);
        checkOutput("rst_mem_row",   32'(mem_row),       32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        ram[1007] = 10'd1;
        ram[1008] = 10'd129;
        ram[1013] = 10'd128;
        ram[1015] = 10'd77;
        ram[1018] = 10'd99;
        ram[21503] = 10'd7;
        ram[500] = 10'd321;

        // 2-word read: {1,129} = 1*1024 + 129
        applyStimulus(1'b0, 1'b1, 20'd1007, 20'd0, wc, lat, rc, rd, er);
        checkOutput("rd2_latency", 32'(lat), 32'd3);
        checkOutput("rd2_rdata",   32'(rd),  32'd1153);
        checkOutput("rd2_err",     32'(er),  32'd0);
        checkOutput("rd2_no_row",  32'(rc),  32'd0);

        // 2-word write: 17408 = 17*1024 + 0
        exp_wr = wr_count + 2;
        applyStimulus(1'b1, 1'b1, 20'd1017, 20'd17408, wc, lat, rc, rd, er);
        checkOutput("wr2_latency",  32'(lat),       32'd3);
        checkOutput("wr2_row_cyc",  32'(rc),        32'd2);
        checkOutput("wr2_ram_hi",   32'(ram[1017]), 32'd17);
        checkOutput("wr2_ram_lo",   32'(ram[1018]), 32'd0);
        checkOutput("wr2_count",    32'(wr_count),  32'(exp_wr));
        checkOutput("wr2_keep_rd",  32'(bus.rsp_rdata), 32'd1153);

        applyStimulus(1'b0, 1'b0, 20'd1013, 20'd0, wc, lat, rc, rd, er);
        checkOutput("rd1_latency", 32'(lat), 32'd2);
        checkOutput("rd1_rdata",   32'(rd),  32'd128);

        exp_wr = wr_count + 1;
        applyStimulus(1'b1, 1'b0, 20'd1014, 20'd5, wc, lat, rc, rd, er);
        checkOutput("b2b_wait",      32'(wc),        32'd0);
        checkOutput("wr1_latency",   32'(lat),       32'd2);
        checkOutput("wr1_row_cyc",   32'(rc),        32'd1);
        checkOutput("wr1_ram",       32'(ram[1014]), 32'd5);
        checkOutput("wr1_neighbour", 32'(ram[1015]), 32'd77);
        checkOutput("wr1_count",     32'(wr_count),  32'(exp_wr));
        checkOutput("wr1_keep_rd",   32'(bus.rsp_rdata), 32'd128);

        // Range boundaries around the last valid word 21503
        applyStimulus(1'b0, 1'b1, 20'd21503, 20'd0, wc, lat, rc, rd, er);
        checkOutput("err_latency",  32'(lat),      32'd0);
        checkOutput("err_flag",     32'(er),       32'd1);
        checkOutput("err_rdata",    32'(rd),       32'd0);
        checkOutput("err_no_row",   32'(rc),       32'd0);
        checkOutput("err_mem_addr", 32'(mem_addr), 32'd1014);
        checkOutput("err_ready",    32'(bus.req_ready), 32'd1);

        applyStimulus(1'b0, 1'b0, 20'd21503, 20'd0, wc, lat, rc, rd, er);
        checkOutput("last_rd_err",   32'(er), 32'd0);
        checkOutput("last_rd_rdata", 32'(rd), 32'd7);

        applyStimulus(1'b0, 1'b0, 20'd21504, 20'd0, wc, lat, rc, rd, er);
        checkOutput("past_end_err", 32'(er), 32'd1);

        exp_wr = wr_count;
        applyStimulus(1'b1, 1'b1, 20'd21503, 20'd12345, wc, lat, rc, rd, er);
        checkOutput("err_wr_flag",  32'(er),         32'd1);
        checkOutput("err_wr_row",   32'(rc),         32'd0);
        checkOutput("err_wr_count", 32'(wr_count),   32'(exp_wr));
        checkOutput("err_wr_ram",   32'(ram[21503]), 32'd7);

        // Reset asserted mid-cycle during WR1
        exp_wr = wr_count;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_dbl   = 1'b0;
        bus.req_addr  = 20'd500;
        bus.req_wdata = 20'd3;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_row_low", 32'(mem_row), 32'd0);
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) vcount++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) vcount++;
        end
        checkOutput("abort_no_rsp", 32'(vcount),    32'd0);
        checkOutput("abort_ram",    32'(ram[500]),  32'd321);
        checkOutput("abort_count",  32'(wr_count),  32'(exp_wr));
        checkOutput("abort_ready",  32'(bus.req_ready), 32'd1);

        // Random stream over a 32-word window
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 10'($urandom_range(0, 1023));
            ram[2000 + i] = ref_mem[i];
        end
        exp_wr = wr_count;
        for (int t = 0; t < 24; t++) begin
            logic              w, d;
            int                off;
            logic [2*DATA_W-1:0] wd;
            w   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            off = $urandom_range(0, 30);
            wd  = 20'($urandom);
            applyStimulus(w, d, 20'(2000 + off), wd, wc, lat, rc, rd, er);
            checkOutput("rnd_latency", 32'(lat), d ? 32'd3 : 32'd2);
            checkOutput("rnd_err",     32'(er),  32'd0);
            if (w) begin
                if (d) begin
                    ref_mem[off]     = wd[19:10];
                    ref_mem[off + 1] = wd[9:0];
                    exp_wr += 2;
                end else begin
                    ref_mem[off] = wd[9:0];
                    exp_wr += 1;
                end
            end else begin
                exp_rd = d ? {ref_mem[off], ref_mem[off + 1]} : {10'd0, ref_mem[off]};
                checkOutput("rnd_rdata", 32'(rd), 32'(exp_rd));
            end
        end
        checkOutput("rnd_wr_count", 32'(wr_count), 32'(exp_wr));
        for (int i = 0; i < 32; i++) begin
            if (ram[2000 + i] !== ref_mem[i]) checkOutput("rnd_ram_word", 32'(ram[2000 + i]), 32'(ref_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, memory address width.
REQ-002 SHALL have parameter DATA_W, default 10, memory word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 21504, number of valid memory words.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when valid & ready at posedge.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_dbl  input  1  1 = 2-word (2*DATA_W) access, 0 = 1-word.
REQ-010 SHALL have port req_addr  input  ADDR_W  first word address.
REQ-011 SHALL have port req_wdata  input  2*DATA_W  write data; high word first.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  output  2*DATA_W  read data.
REQ-014 SHALL have port rsp_err  output  1  address range error; valid with rsp_valid.
REQ-015 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-016 SHALL have port mem_row  output  1  memory read(0)/write(1) select.
REQ-017 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-018 SHALL have port mem_rdata  input  DATA_W  memory read data.

Function
REQ-019 SHALL target a memory that latches mem_rdata = ram[mem_addr] at posedge when mem_row=0 and writes ram[mem_addr] = mem_wdata at negedge when mem_row=1.
REQ-020 SHALL drive mem_addr, mem_row and mem_wdata only from posedge registers, so they are stable across the negedge write.
REQ-021 SHALL use the FSM states IDLE, RD1, RD2, RD3, WR1, WR2.
REQ-022 SHALL assert req_ready only in IDLE.
REQ-023 SHALL hold mem_row=0 in every state except WR1 and WR2.
REQ-024 On accept, SHALL go to RD1 for a read or WR1 for a write, with mem_addr=req_addr.
REQ-025 A 2-word access SHALL store the high word at A and the low word at A+1; A+1 is computed modulo 2^ADDR_W.
REQ-026 On accept, SHALL check the range: error if A >= MEM_DEPTH, or if req_dbl and A+1 >= MEM_DEPTH.
REQ-027 On a range error: no state change to RD/WR, mem_row stays 0, and next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-028 Read timing:
- RD1: address A presented.
- On exit, a 1-word read goes to RD3.
- A 2-word read sets mem_addr=A+1 and goes to RD2.
REQ-029 RD2 SHALL capture mem_rdata into rsp_rdata[2*DATA_W-1:DATA_W], then go to RD3.
REQ-030 RD3 SHALL capture mem_rdata into:
- rsp_rdata[DATA_W-1:0] for a 2-word read;
- the low word, with the high word zeroed, for a 1-word read.
REQ-031 RD3 SHALL then pulse rsp_valid and return to IDLE.
REQ-032 Read latency, accept edge to rsp_valid: 2 cycles for 1-word, 3 cycles for 2-word.
REQ-033 Write timing, WR1: mem_row=1, mem_wdata = high word (2-word) or req_wdata[DATA_W-1:0] (1-word).
REQ-034 A 2-word write SHALL go from WR1 to WR2 with mem_addr=A+1 and mem_wdata = low word.
REQ-035 The final write state SHALL pulse rsp_valid on exit, return to IDLE and set mem_row=0 on the same edge.
REQ-036 Write latency: 2 cycles for 1-word, 3 cycles for 2-word; exactly one memory write per word.
REQ-037 SHALL latch request fields at accept; request inputs are ignored while not in IDLE.
REQ-038 Back-to-back: a new request SHALL be acceptable on the posedge after rsp_valid is asserted.
REQ-039 rsp_rdata SHALL hold its last value until the next read completes.

Reset
REQ-040 While rst_n=0, SHALL be in state IDLE with req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_row=0, mem_wdata=0.
REQ-041 SHALL take reset asynchronously: mem_row falls immediately, so a reset during WR1/WR2 blocks the pending negedge write, and the aborted access produces no rsp_valid.

Verification
REQ-042 Preload ram[1007]=1, ram[1008]=129; 2-word read A=1007 -> rsp_valid 3 cycles after accept, rsp_rdata=1153, rsp_err=0.
REQ-043 2-word write A=1017, wdata=17408 -> ram[1017]=17, ram[1018]=0, rsp_valid after 3 cycles; mem_row=1 for exactly 2 cycles.
REQ-044 1-word read A=1013 with ram=128 -> rsp_rdata=128 after 2 cycles; then a back-to-back 1-word write A=1014, wdata=5 -> ram[1014]=5.
REQ-045 2-word read A=21503 -> rsp_valid, rsp_err=1 next cycle, mem_row never 1, no memory read sequence.
REQ-046 Assert rst_n=0 mid-cycle during WR1 of a write to A=500 -> ram[500] unchanged, no rsp_valid; IDLE with req_ready=1 after release.
REQ-047 Random request stream vs reference memory model -> all read data matches, with zero writes while not in WR1/WR2.
